// File: rtl/seg_entry_ctrl.sv
// Front-panel digit entry: debounced KEY events write SW nibbles into a 4-digit
// store shown on HEX0..HEX3, with an optional blinking cursor digit.
module seg_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1250000,
    parameter int BLINK_CYCLES    = 62500000
) (
    input  logic       CLOCK_125_p,
    input  logic       CPU_RESET_n,
    input  logic [3:0] KEY,
    input  logic [3:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [1:0] cursor
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int BL_W = $clog2(BLINK_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);

    localparam int KEY_COMMIT  = 0;
    localparam int KEY_ADVANCE = 1;
    localparam int KEY_CLEAR   = 2;
    localparam int KEY_TOGGLE  = 3;

    typedef enum logic {
        PH_VISIBLE = 1'b0,
        PH_BLANK   = 1'b1
    } phase_e;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // ---------------------------------------------------------------- sync
    logic [3:0] key_meta, key_sync;
    logic [3:0] sw_meta, sw_sync;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK_125_p) begin
        if (!CPU_RESET_n) begin
            key_meta <= 4'hF;
            key_sync <= 4'hF;
            sw_meta  <= 4'h0;
            sw_sync  <= 4'h0;
        end else begin
            key_meta <= KEY;
            key_sync <= key_meta;
            sw_meta  <= SW;
            sw_sync  <= sw_meta;
        end
    end

    // ------------------------------------------------------------ debounce
    logic [DB_W-1:0] db_cnt     [4];
    logic [DB_W-1:0] db_cnt_nxt [4];
    logic [3:0]      key_stable, key_stable_nxt, key_stable_prev;
    logic [3:0]      press_evt;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        key_stable_nxt = key_stable;
        for (int i = 0; i < 4; i++) begin
            db_cnt_nxt[i] = '0;
            if (key_sync[i] != key_stable[i]) begin
                if (db_cnt[i] == DB_LAST) begin
                    key_stable_nxt[i] = ~key_stable[i];
                end else begin
                    db_cnt_nxt[i] = db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLOCK_125_p) begin
        if (!CPU_RESET_n) begin
            key_stable      <= 4'hF;
            key_stable_prev <= 4'hF;
            press_evt       <= 4'h0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            key_stable      <= key_stable_nxt;
            key_stable_prev <= key_stable;
            // Falling stable level (released -> pressed) yields one pulse.
            press_evt       <= key_stable_prev & ~key_stable;
            for (int i = 0; i < 4; i++) db_cnt[i] <= db_cnt_nxt[i];
        end
    end

    // ------------------------------------------------------ digit store
    logic [3:0]      digits     [4];
    logic [3:0]      digits_nxt [4];
    logic [1:0]      cursor_nxt;
    logic            cursor_move;
    logic            blink_en, blink_en_nxt;
    logic [BL_W-1:0] blink_cnt, blink_cnt_nxt;
    phase_e          phase, phase_nxt;

    // Clear beats commit beats advance; toggle is handled independently.
    always_comb begin
        digits_nxt  = digits;
        cursor_nxt  = cursor;
        cursor_move = 1'b0;
        if (press_evt[KEY_CLEAR]) begin
            for (int i = 0; i < 4; i++) digits_nxt[i] = 4'h0;
            cursor_nxt  = 2'd0;
            cursor_move = 1'b1;
        end else if (press_evt[KEY_COMMIT]) begin
            digits_nxt[cursor] = sw_sync;
            cursor_nxt  = cursor + 2'd1;
            cursor_move = 1'b1;
        end else if (press_evt[KEY_ADVANCE]) begin
            cursor_nxt  = cursor + 2'd1;
            cursor_move = 1'b1;
        end
    end

    always_comb begin
        blink_en_nxt  = blink_en;
        blink_cnt_nxt = blink_cnt;
        phase_nxt     = phase;
        if (press_evt[KEY_TOGGLE]) begin
            blink_en_nxt  = ~blink_en;
            blink_cnt_nxt = '0;
            phase_nxt     = PH_VISIBLE;
        end else if (cursor_move) begin
            // Restart visible so the new cursor position is seen at once.
            blink_cnt_nxt = '0;
            phase_nxt     = PH_VISIBLE;
        end else if (blink_en) begin
            if (blink_cnt == BL_LAST) begin
                blink_cnt_nxt = '0;
                phase_nxt     = (phase == PH_VISIBLE) ? PH_BLANK : PH_VISIBLE;
            end else begin
                blink_cnt_nxt = blink_cnt + BL_W'(1);
            end
        end
    end

    // NOTE: the digit store is only four nibbles of flops, so it is reset like
    // any other state; a RAM-sized array would be left unreset instead.
    always_ff @(posedge CLOCK_125_p) begin
        if (!CPU_RESET_n) begin
            for (int i = 0; i < 4; i++) digits[i] <= 4'h0;
            cursor    <= 2'd0;
            blink_en  <= 1'b1;
            blink_cnt <= '0;
            phase     <= PH_VISIBLE;
        end else begin
            for (int i = 0; i < 4; i++) digits[i] <= digits_nxt[i];
            cursor    <= cursor_nxt;
            blink_en  <= blink_en_nxt;
            blink_cnt <= blink_cnt_nxt;
            phase     <= phase_nxt;
        end
    end

    // -------------------------------------------------------- output stage
    logic [6:0] hex_nxt [4];

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            if (blink_en && (phase == PH_BLANK) && (cursor == 2'(n))) begin
                hex_nxt[n] = 7'h7F;
            end else begin
                hex_nxt[n] = seg_decode(digits[n]);
            end
        end
    end

    always_ff @(posedge CLOCK_125_p) begin
        if (!CPU_RESET_n) begin
            HEX0 <= 7'h40;
            HEX1 <= 7'h40;
            HEX2 <= 7'h40;
            HEX3 <= 7'h40;
        end else begin
            HEX0 <= hex_nxt[0];
            HEX1 <= hex_nxt[1];
            HEX2 <= hex_nxt[2];
            HEX3 <= hex_nxt[3];
        end
    end

endmodule

// File: tb/tb_seg_entry_ctrl.sv
// Directed bench for seg_entry_ctrl with DEBOUNCE_CYCLES=4, BLINK_CYCLES=8.
module tb_seg_entry_ctrl;

    logic       CLOCK_125_p = 1'b0;
    logic       CPU_RESET_n = 1'b0;
    logic [3:0] KEY = 4'hF;
    logic [3:0] SW  = 4'h0;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;
    logic [1:0] cursor;

    int total = 0;
    int bad   = 0;

    seg_entry_ctrl #(.DEBOUNCE_CYCLES(4), .BLINK_CYCLES(8)) dut (
        .CLOCK_125_p(CLOCK_125_p),
        .CPU_RESET_n(CPU_RESET_n),
        .KEY        (KEY),
        .SW         (SW),
        .HEX0       (HEX0),
        .HEX1       (HEX1),
        .HEX2       (HEX2),
        .HEX3       (HEX3),
        .cursor     (cursor)
    );

    always #4 CLOCK_125_p = ~CLOCK_125_p;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] hex_sel(input int n);
        case (n)
            0: return HEX0;
            1: return HEX1;
            2: return HEX2;
            default: return HEX3;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_125_p);
    endtask

    task automatic do_reset();
        CPU_RESET_n = 1'b0;
        KEY = 4'hF;
        tick(3);
        CPU_RESET_n = 1'b1;
    endtask

    // Hold the given keys pressed, then release and let the release settle.
    task automatic press(input logic [3:0] mask, input int hold);
        KEY = ~mask;
        tick(hold);
        KEY = 4'hF;
        tick(12);
    endtask

    // Returns the first non-blank value of digit n within a bounded wait.
    task automatic wait_visible(input int n, output logic [6:0] val);
        val = hex_sel(n);
        for (int i = 0; i < 20 && val == 7'h7F; i++) begin
            tick(1);
            val = hex_sel(n);
        end
    endtask

    task automatic test_reset();
        logic [6:0] exp;
        CPU_RESET_n = 1'b0;
        KEY = 4'hF;
        tick(3);
        total++;
        if ({HEX0, HEX1, HEX2, HEX3} !== {4{7'h40}}) begin
            bad++;
            $display("FAIL reset_hex: got %h %h %h %h want 40 x4", HEX0, HEX1, HEX2, HEX3);
        end
        total++;
        if (cursor !== 2'd0) begin
            bad++;
            $display("FAIL reset_cursor: got %0d want 0", cursor);
        end
        CPU_RESET_n = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick(1);
            exp = (((k - 1) / 8) % 2 == 1) ? 7'h7F : 7'h40;
            total++;
            if (HEX0 !== exp) begin
                bad++;
                $display("FAIL blink_hex0_cycle%0d: got %h want %h", k, HEX0, exp);
            end
        end
        total++;
        if ({HEX1, HEX2, HEX3} !== {3{7'h40}} || cursor !== 2'd0) begin
            bad++;
            $display("FAIL idle_state: got %h %h %h cur=%0d want 40 40 40 cur=0", HEX1, HEX2, HEX3, cursor);
        end
    endtask

    task automatic test_commit();
        int seen_at = -1;
        logic [6:0] hex_at8 = 7'h7F;
        logic [6:0] hex_at9 = 7'h7F;
        SW = 4'hA;
        tick(3);
        KEY = 4'b1110;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (cursor == 2'd1 && seen_at < 0) seen_at = i;
            if (i == 8) hex_at8 = HEX0;
            if (i == 9) hex_at9 = HEX0;
        end
        KEY = 4'hF;
        tick(12);
        total++;
        if (seen_at !== 8) begin
            bad++;
            $display("FAIL commit_latency: got %0d want 8", seen_at);
        end
        total++;
        if (hex_at8 !== 7'h40 || hex_at9 !== 7'h08) begin
            bad++;
            $display("FAIL commit_hex_timing: got %h,%h want 40,08", hex_at8, hex_at9);
        end
        tick(20);
        total++;
        if (cursor !== 2'd1 || HEX0 !== 7'h08 || HEX2 !== 7'h40) begin
            bad++;
            $display("FAIL commit_once: got cur=%0d hex0=%h hex2=%h want cur=1 hex0=08 hex2=40", cursor, HEX0, HEX2);
        end
    endtask

    task automatic test_glitch();
        for (int r = 0; r < 5; r++) begin
            KEY = 4'b1110;
            tick(2);
            KEY = 4'hF;
            tick(2);
        end
        tick(20);
        total++;
        if (cursor !== 2'd1 || HEX0 !== 7'h08 || HEX2 !== 7'h40 || HEX3 !== 7'h40) begin
            bad++;
            $display("FAIL glitch_reject: got cur=%0d hex0=%h hex2=%h hex3=%h want cur=1 08 40 40", cursor, HEX0, HEX2, HEX3);
        end
    endtask

    task automatic test_wrap();
        logic [6:0] h1;
        do_reset();
        for (int v = 1; v <= 5; v++) begin
            SW = 4'(v);
            tick(3);
            press(4'b0001, 12);
        end
        total++;
        if (cursor !== 2'd1) begin
            bad++;
            $display("FAIL wrap_cursor: got %0d want 1", cursor);
        end
        total++;
        if (HEX0 !== 7'h12 || HEX2 !== 7'h30 || HEX3 !== 7'h19) begin
            bad++;
            $display("FAIL wrap_digits: got %h %h %h want 12 30 19", HEX0, HEX2, HEX3);
        end
        wait_visible(1, h1);
        total++;
        if (h1 !== 7'h24) begin
            bad++;
            $display("FAIL wrap_hex1: got %h want 24", h1);
        end
    endtask

    task automatic test_clear_priority();
        logic [6:0] h0;
        SW = 4'h7;
        tick(3);
        press(4'b0101, 12);
        total++;
        if (cursor !== 2'd0 || {HEX1, HEX2, HEX3} !== {3{7'h40}}) begin
            bad++;
            $display("FAIL clear_priority: got cur=%0d %h %h %h want cur=0 40 40 40", cursor, HEX1, HEX2, HEX3);
        end
        wait_visible(0, h0);
        total++;
        if (h0 !== 7'h40) begin
            bad++;
            $display("FAIL clear_hex0: got %h want 40", h0);
        end
    endtask

    task automatic test_toggle();
        int guard;
        int static_bad = 0;
        guard = 0;
        while (HEX0 !== 7'h7F && guard < 40) begin
            tick(1);
            guard++;
        end
        guard = 0;
        while (HEX0 === 7'h7F && guard < 40) begin
            tick(1);
            guard++;
        end
        total++;
        if (HEX0 !== 7'h40) begin
            bad++;
            $display("FAIL toggle_align: got %h want 40", HEX0);
        end
        // Phase just turned visible; the toggle lands during the next blank half.
        KEY = 4'b0111;
        tick(8);
        total++;
        if (HEX0 !== 7'h7F) begin
            bad++;
            $display("FAIL toggle_pre_blank: got %h want 7f", HEX0);
        end
        tick(1);
        total++;
        if (HEX0 !== 7'h40) begin
            bad++;
            $display("FAIL toggle_off_visible: got %h want 40", HEX0);
        end
        for (int i = 0; i < 50; i++) begin
            if (i == 5) KEY = 4'hF;
            tick(1);
            if (HEX0 !== 7'h40) static_bad++;
        end
        total++;
        if (static_bad !== 0) begin
            bad++;
            $display("FAIL toggle_static: got %0d blank cycles want 0", static_bad);
        end
        KEY = 4'b0111;
        for (int i = 1; i <= 17; i++) begin
            tick(1);
            if (i == 16) begin
                total++;
                if (HEX0 !== 7'h40) begin
                    bad++;
                    $display("FAIL toggle_on_visible_first: got %h want 40", HEX0);
                end
            end
            if (i == 17) begin
                total++;
                if (HEX0 !== 7'h7F) begin
                    bad++;
                    $display("FAIL toggle_on_blank: got %h want 7f", HEX0);
                end
            end
        end
        KEY = 4'hF;
        tick(12);
    endtask

    task automatic test_reset_mid_debounce();
        press(4'b0010, 12);
        total++;
        if (cursor !== 2'd1) begin
            bad++;
            $display("FAIL advance: got %0d want 1", cursor);
        end
        SW = 4'h9;
        tick(3);
        KEY = 4'b1110;
        tick(4);
        CPU_RESET_n = 1'b0;
        KEY = 4'hF;
        tick(2);
        CPU_RESET_n = 1'b1;
        tick(30);
        total++;
        if (cursor !== 2'd0 || {HEX1, HEX2, HEX3} !== {3{7'h40}}) begin
            bad++;
            $display("FAIL reset_mid_debounce: got cur=%0d %h %h %h want cur=0 40 40 40", cursor, HEX1, HEX2, HEX3);
        end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_glitch();
        test_wrap();
        test_clear_priority();
        test_toggle();
        test_reset_mid_debounce();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
